// File: rtl/wb_unit.sv
// wb_unit: writeback stage. Picks the register-file write source, waits for
// the data-memory response on loads, extracts and extends the loaded data,
// drives the register-file write port, and counts retired instructions.
module wb_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       wb_sel,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rd,
    input  logic             reg_write,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    state_t            r_state;
    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;
    logic [XLEN-1:0]   r_rf_wdata;
    logic [CNT_W-1:0]  r_retired;

    // latched load context, held while the memory response is outstanding
    logic [4:0]        r_ld_rd;
    logic              r_ld_we;
    logic [2:0]        r_ld_f3;
    logic [1:0]        r_ld_off;

    logic [XLEN-1:0]   w_nonload;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [XLEN-1:0]   w_load;
    logic              w_accept;

    assign in_ready = (r_state == IDLE) && !rst;
    assign busy     = (r_state == WAIT_MEM);
    assign w_accept = in_valid && in_ready;

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign retired  = r_retired;

    // non-load writeback source mux
    always_comb begin
        w_nonload = imm;
        case (wb_sel)
            SEL_ALU: w_nonload = alu_result;
            SEL_PC4: w_nonload = pc + XLEN'(4);
            default: w_nonload = imm;
        endcase
    end

    // byte/half lane select and sign/zero extension of the load response
    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_ld_off)
            2'd0: w_byte = mem_rdata[7:0];
            2'd1: w_byte = mem_rdata[15:8];
            2'd2: w_byte = mem_rdata[23:16];
            2'd3: w_byte = mem_rdata[31:24];
            default: w_byte = mem_rdata[7:0];
        endcase
        w_half = r_ld_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_ld_f3)
            3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    // writeback FSM with registered register-file port and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_retired  <= '0;
            r_ld_rd    <= '0;
            r_ld_we    <= 1'b0;
            r_ld_f3    <= '0;
            r_ld_off   <= '0;
        end else begin
            r_rf_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (wb_sel == SEL_LOAD) begin
                            r_ld_rd  <= rd;
                            r_ld_we  <= reg_write;
                            r_ld_f3  <= funct3;
                            r_ld_off <= alu_result[1:0];
                            r_state  <= WAIT_MEM;
                        end else begin
                            // address/data only move on a real write so they hold otherwise
                            if (reg_write && (rd != 5'd0)) begin
                                r_rf_we    <= 1'b1;
                                r_rf_waddr <= rd;
                                r_rf_wdata <= w_nonload;
                            end
                            r_retired <= r_retired + CNT_W'(1);
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        if (r_ld_we && (r_ld_rd != 5'd0)) begin
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= r_ld_rd;
                            r_rf_wdata <= w_load;
                        end
                        r_retired <= r_retired + CNT_W'(1);
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: scoreboard bench for wb_unit. Stimulus pushes expected
// register-file writes into a queue; a monitor pops and compares them.
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  wb_sel;
    logic [31:0] alu_result;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic [31:0] retired;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_ret = '0;

    // pending load context as the bench remembers it
    logic [4:0]  ld_rd;
    logic        ld_rw;
    logic [2:0]  ld_f3;
    logic [1:0]  ld_off;

    wb_unit #(.XLEN(32), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wb_sel     (wb_sel),
        .alu_result (alu_result),
        .pc         (pc),
        .imm        (imm),
        .funct3     (funct3),
        .rd         (rd),
        .reg_write  (reg_write),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: register value a load produces, from size/sign rules
    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        longint b;
        longint h;
        b = (longint'(w) >> (8 * off)) & 'hff;
        h = (longint'(w) >> (16 * (off / 2))) & 'hffff;
        case (f3)
            3'b000: return (b > 127) ? 32'(b - 256) : 32'(b);
            3'b100: return 32'(b);
            3'b001: return (h > 32767) ? 32'(h - 65536) : 32'(h);
            3'b101: return 32'(h);
            default: return w;
        endcase
    endfunction

    // reference: register value a non-load instruction produces
    function automatic logic [31:0] nonload_model(input logic [1:0] s, input logic [31:0] a,
                                                  input logic [31:0] p, input logic [31:0] im);
        longint sum;
        sum = (longint'(p) + 4) % (longint'(1) << 32);
        case (s)
            2'b00:   return a;
            2'b10:   return 32'(sum);
            default: return im;
        endcase
    endfunction

    // monitor: every register-file write must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && rf_we === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_write_addr", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", {27'd0, rf_waddr}, {27'd0, e.addr});
                chk("wr_data", rf_wdata, e.data);
            end
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // present one instruction; leaves in_valid high so callers can chain
    task automatic issue(input logic [1:0] s, input logic [31:0] a, input logic [31:0] p,
                         input logic [31:0] im, input logic [2:0] f3, input logic [4:0] r,
                         input logic rw);
        chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        wb_sel     = s;
        alu_result = a;
        pc         = p;
        imm        = im;
        funct3     = f3;
        rd         = r;
        reg_write  = rw;
        if (s != 2'b01) begin
            if (rw && r != 5'd0) q.push_back('{r, nonload_model(s, a, p, im)});
            exp_ret++;
        end else begin
            ld_rd  = r;
            ld_rw  = rw;
            ld_f3  = f3;
            ld_off = a[1:0];
        end
        @(posedge clk);
        #1;
        chk("retired_after_issue", retired, exp_ret);
        if (s == 2'b01) begin
            chk("busy_after_load", {31'd0, busy}, 32'd1);
            chk("no_we_after_load", {31'd0, rf_we}, 32'd0);
        end
    endtask

    // hold off the memory response for 'wait_cyc' cycles, then deliver it
    task automatic mem_resp(input int unsigned wait_cyc, input logic [31:0] w);
        for (int unsigned i = 0; i < wait_cyc; i++) begin
            chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
            chk("wait_busy", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
            chk("wait_no_we", {31'd0, rf_we}, 32'd0);
        end
        in_valid   = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = w;
        if (ld_rw && ld_rd != 5'd0) q.push_back('{ld_rd, load_model(ld_f3, ld_off, w)});
        exp_ret++;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        chk("retired_after_load", retired, exp_ret);
        chk("in_ready_after_load", {31'd0, in_ready}, 32'd1);
        chk("busy_after_load_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] s;
        logic [4:0] r;
        logic       rw;

        rst = 1'b1; in_valid = 1'b0; wb_sel = '0; alu_result = '0; pc = '0; imm = '0;
        funct3 = '0; rd = '0; reg_write = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #2;
        chk("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
        #10 rst = 1'b0;
        #1;
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // ALU op, then rf_we must drop
        issue(2'b00, 32'h0000_1234, 32'h0, 32'h0, 3'd0, 5'd5, 1'b1);
        chk("t1_we", {31'd0, rf_we}, 32'd1);
        chk("t1_retired", retired, 32'd1);
        idle();
        chk("t1_we_drop", {31'd0, rf_we}, 32'd0);

        // back-to-back PC+4 wraparound then LUI
        issue(2'b10, 32'h0, 32'hFFFF_FFFC, 32'h0, 3'd0, 5'd1, 1'b1);
        issue(2'b11, 32'h0, 32'h0, 32'hABCD_E000, 3'd0, 5'd2, 1'b1);
        chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
        idle();

        // load extraction cases
        issue(2'b01, 32'h0000_1003, 32'h0, 32'h0, 3'b000, 5'd7, 1'b1);
        mem_resp(0, 32'h8011_2233);
        chk("t3_lb", rf_wdata, 32'hFFFF_FF80);
        issue(2'b01, 32'h0000_1003, 32'h0, 32'h0, 3'b100, 5'd8, 1'b1);
        mem_resp(1, 32'h8011_2233);
        chk("t3_lbu", rf_wdata, 32'h0000_0080);
        issue(2'b01, 32'h0000_2002, 32'h0, 32'h0, 3'b001, 5'd9, 1'b1);
        mem_resp(0, 32'h8001_7FFF);
        chk("t3_lh", rf_wdata, 32'hFFFF_8001);
        issue(2'b01, 32'h0000_2002, 32'h0, 32'h0, 3'b101, 5'd10, 1'b1);
        mem_resp(2, 32'h8001_7FFF);
        chk("t3_lhu", rf_wdata, 32'h0000_8001);

        // long load wait with in_valid held high
        issue(2'b01, 32'h0000_3000, 32'h0, 32'h0, 3'b010, 5'd11, 1'b1);
        mem_resp(4, 32'h1357_9BDF);
        chk("t4_we", {31'd0, rf_we}, 32'd1);
        idle();

        // rd=0 completes without writing; stray rvalid in IDLE ignored
        issue(2'b00, 32'hDEAD_BEEF, 32'h0, 32'h0, 3'd0, 5'd0, 1'b1);
        chk("t5_no_we", {31'd0, rf_we}, 32'd0);
        in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("t5_stray_retired", retired, exp_ret);
        chk("t5_stray_busy", {31'd0, busy}, 32'd0);
        chk("t5_stray_we", {31'd0, rf_we}, 32'd0);

        // randomized mix
        for (int unsigned n = 0; n < 300; n++) begin
            s  = 2'($urandom_range(0, 3));
            r  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rw = ($urandom_range(0, 4) != 0);
            issue(s, $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)), r, rw);
            if (s == 2'b01) mem_resp($urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();

        // asynchronous reset while a load is outstanding
        issue(2'b01, 32'h0000_4001, 32'h0, 32'h0, 3'b000, 5'd12, 1'b1);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("t6_we", {31'd0, rf_we}, 32'd0);
        chk("t6_wdata", rf_wdata, 32'd0);
        chk("t6_retired", retired, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        exp_ret = '0;
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(posedge clk); #1;
        chk("t6_post_retired", retired, 32'd0);
        chk("t6_post_busy", {31'd0, busy}, 32'd0);
        chk("t6_post_in_ready", {31'd0, in_ready}, 32'd1);
        chk("queue_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
Writeback stage of the RISC-V core. It is the consumer of the ALU result path and the counterpart of the operand-select logic in front of the ALU.
- Accepts one completed instruction per handshake.
- Selects the writeback source: ALU result, load data, PC+4 or immediate.
- For loads, waits for the data-memory response, then byte/half extracts and sign/zero extends the data.
- Drives the register-file write port and counts retired instructions.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  upstream has an instruction for writeback
in_ready  output  1  unit can accept an instruction this cycle
wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 imm (LUI)
alu_result  input  XLEN  ALU output; also the load address for loads
pc  input  XLEN  instruction PC
imm  input  XLEN  decoded immediate
funct3  input  3  load size/sign; used only when wb_sel=01
rd  input  5  destination register
reg_write  input  1  instruction writes rd
mem_rvalid  input  1  data-memory read response valid, single-cycle pulse
mem_rdata  input  XLEN  data-memory read word, aligned
rf_we  output  1  register-file write enable, one-cycle pulse
rf_waddr  output  5  register-file write address
rf_wdata  output  XLEN  register-file write data
busy  output  1  load outstanding
retired  output  CNT_W  count of accepted-and-completed instructions

Behaviour:
- The clock is clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - state=IDLE
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - retired=0
  - pending registers cleared
  - in_ready=1 while rst is low and state=IDLE; busy=0.
- FSM states:
  - IDLE: in_ready=1, busy=0.
  - WAIT_MEM: in_ready=0, busy=1.
- Acceptance: an instruction is accepted on a rising edge where in_valid && in_ready.
- Non-load accept in IDLE (wb_sel≠01):
  - Next cycle: rf_wdata = alu_result / pc+4 (mod 2^32) / imm per wb_sel.
  - rf_waddr=rd; rf_we = reg_write && (rd≠0).
  - State stays IDLE. Back-to-back accepts are allowed, so throughput is 1 per cycle and latency is 1.
- Load accept in IDLE (wb_sel=01):
  - Latch rd, reg_write, funct3 and alu_result[1:0], then go to WAIT_MEM.
  - rf_we=0 on the next cycle.
- In WAIT_MEM with mem_rvalid=1:
  - Next cycle: rf_wdata = extracted value, rf_waddr = latched rd, rf_we = latched reg_write && rd≠0.
  - State returns to IDLE.
  - Minimum load latency is 2 cycles from accept; there is no timeout.
- Load extraction, with off = latched addr[1:0]:
  - 000 LB: byte mem_rdata[8*off+7:8*off], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half selected by off[1], sign-extended; off[0] is ignored.
  - 101 LHU: same half, zero-extended.
  - 010 LW, and 011/110/111: the full word; offset ignored.
- mem_rvalid in IDLE is ignored, with no state or output change.
- rf_we is high for exactly one cycle per write. When no write occurs, rf_waddr and rf_wdata hold their last values.
- retired:
  - Increments by 1 on the cycle rf_we would be asserted for any completed instruction, including rd=0 or reg_write=0.
  - Non-load completes 1 cycle after accept; load completes on the mem_rvalid cycle's following edge.
  - Wraps from 2^CNT_W−1 to 0.
- Reset mid-operation (rst asserted in WAIT_MEM):
  - Pending load is dropped and returns to IDLE; outputs go to reset values immediately.
  - A mem_rvalid arriving after reset is released is ignored.

Test Plan:
1. ALU op: wb_sel=00, alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, retired=1; the following cycle rf_we=0.
2. Back-to-back: PC+4 (pc=0xFFFF_FFFC, rd=1) then LUI (imm=0xABCD_E000, rd=2) on consecutive cycles -> rf_wdata=0x0000_0000, then 0xABCD_E000, on consecutive cycles; in_ready stays 1.
3. Load extract:
   - LB, addr off=3, mem_rdata=0x80_11_22_33 -> rf_wdata=0xFFFF_FF80.
   - LBU, same inputs -> 0x0000_0080.
   - LH, off=2, mem_rdata=0x8001_7FFF -> 0xFFFF_8001.
   - LHU, same inputs -> 0x0000_8001.
4. Load wait: load accepted, mem_rvalid held low 4 cycles with in_valid=1 -> in_ready=0 and busy=1 throughout, no rf_we; mem_rvalid pulse -> rf_we one cycle later, then in_ready=1.
5. rd=0: ALU op with rd=0, reg_write=1, value 0xDEAD_BEEF -> rf_we stays 0, retired increments; a stray mem_rvalid in IDLE -> no change.
6. Reset in WAIT_MEM: assert rst asynchronously mid-cycle -> rf_we=0, rf_wdata=0, retired=0, busy=0 immediately; a mem_rvalid after release -> no write.
